e_mdu: RTL

Execute-stage multiply/divide unit with architectural HI/LO registers. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO operations from the E stage and runs multi-cycle products and quotients behind a busy flag. It returns HI/LO reads on `mdu_out`, which the E/M pipeline register captures as `MDUOut_E`. The hazard unit stalls the D stage using `stall_req`.

---
 rtl/e_mdu.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit holding the architectural HI/LO pair.
// Define MDU_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate ops (9-12).
module e_mdu #(
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid,
   input  logic [3:0]  mdu_op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic        busy,
   output logic        stall_req,
   output logic [31:0] mdu_out,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } state_e;

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
   localparam logic [3:0] OP_MADD  = 4'd9;
   localparam logic [3:0] OP_MADDU = 4'd10;
   localparam logic [3:0] OP_MSUB  = 4'd11;
   localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

   localparam logic [3:0] MULT_CNT = 4'(MULT_LAT - 1);
   localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT - 1);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        busy_q, busy_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic [31:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;

   logic        is_mul_s, is_div_s;
   logic [63:0] prod_signed_s, prod_unsigned_s, mul_res_s;
   logic [31:0] quo_s, rem_s;

   // Decode which operations start a multi-cycle sequence
   always_comb begin
      is_mul_s = 1'b0;
      is_div_s = 1'b0;
      case (mdu_op)
         OP_MULT, OP_MULTU: is_mul_s = 1'b1;
         OP_DIV, OP_DIVU:   is_div_s = 1'b1;
`ifdef MDU_MADD_EN
         OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_mul_s = 1'b1;
`endif
         default: begin
            is_mul_s = 1'b0;
            is_div_s = 1'b0;
         end
      endcase
   end

   // Products and (optionally) the accumulate against {HI,LO} at the start edge
   always_comb begin
      prod_signed_s   = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
      prod_unsigned_s = {32'd0, rs_val} * {32'd0, rt_val};
      mul_res_s       = prod_signed_s;
      case (mdu_op)
         OP_MULTU: mul_res_s = prod_unsigned_s;
`ifdef MDU_MADD_EN
         OP_MADD:  mul_res_s = {hi_q, lo_q} + prod_signed_s;
         OP_MADDU: mul_res_s = {hi_q, lo_q} + prod_unsigned_s;
         OP_MSUB:  mul_res_s = {hi_q, lo_q} - prod_signed_s;
         OP_MSUBU: mul_res_s = {hi_q, lo_q} - prod_unsigned_s;
`endif
         default:  mul_res_s = prod_signed_s;
      endcase
   end

   // Quotient/remainder; a zero divisor recommits the current HI/LO unchanged
   always_comb begin
      quo_s = 32'd0;
      rem_s = 32'd0;
      if (rt_val == 32'd0) begin
         quo_s = lo_q;
         rem_s = hi_q;
      end else if (mdu_op == OP_DIVU) begin
         quo_s = rs_val / rt_val;
         rem_s = rs_val % rt_val;
      end else if (rs_val == 32'h8000_0000 && rt_val == 32'hFFFF_FFFF) begin
         quo_s = 32'h8000_0000;
         rem_s = 32'd0;
      end else begin
         quo_s = $signed(rs_val) / $signed(rt_val);
         rem_s = $signed(rs_val) % $signed(rt_val);
      end
   end

   // Next-state logic for the IDLE/MUL/DIV sequencer and HI/LO updates
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      res_hi_d = res_hi_q;
      res_lo_d = res_lo_q;
      case (state_q)
         ST_IDLE: begin
            if (valid && is_mul_s) begin
               state_d  = ST_MUL;
               cnt_d    = MULT_CNT;
               busy_d   = 1'b1;
               res_hi_d = mul_res_s[63:32];
               res_lo_d = mul_res_s[31:0];
            end else if (valid && is_div_s) begin
               state_d  = ST_DIV;
               cnt_d    = DIV_CNT;
               busy_d   = 1'b1;
               res_hi_d = rem_s;
               res_lo_d = quo_s;
            end else if (valid && mdu_op == OP_MTHI) begin
               hi_d = rs_val;
            end else if (valid && mdu_op == OP_MTLO) begin
               lo_d = rs_val;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_MUL, ST_DIV: begin
            if (cnt_q == 4'd0) begin
               hi_d    = res_hi_q;
               lo_d    = res_lo_q;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State register with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 4'd0;
         busy_q   <= 1'b0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         res_hi_q <= 32'd0;
         res_lo_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         res_hi_q <= res_hi_d;
         res_lo_q <= res_lo_d;
      end
   end

   // HI/LO read port toward the E/M pipeline register
   always_comb begin
      mdu_out = 32'd0;
      if (valid && mdu_op == OP_MFHI) begin
         mdu_out = hi_q;
      end else if (valid && mdu_op == OP_MFLO) begin
         mdu_out = lo_q;
      end else begin
         mdu_out = 32'd0;
      end
   end

   assign stall_req = busy_q | (valid & (is_mul_s | is_div_s));
   assign busy      = busy_q;
   assign hi        = hi_q;
   assign lo        = lo_q;

endmodule
